dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side end of the tagged proc2mem/mem2proc bus driven by the dcache controller.
//  - Accepts one BUS_LOAD or BUS_STORE per cycle and returns an issue tag combinationally,
//    or 0 when it rejects the command.
//  - Returns the completion tag, plus load data, a fixed LATENCY cycles later.
//  - Holds the backing data store. Serves as synthesizable data memory and as the bench model.
// PARAMETERS
//  ADDR_BITS  10  word-index width; the store holds 2**ADDR_BITS 64-bit words
//  NUM_TAGS   15  outstanding-request slots, tags 1..NUM_TAGS; legal range 1..15
//  LATENCY     4  cycles from accept to completion; legal range 1..15
// PORTS
//  clock              in   1   system clock; the single clock domain
//  reset              in   1   synchronous, active-high reset
//  proc2mem_command   in   2   0=BUS_NONE, 1=BUS_LOAD, 2=BUS_STORE, 3=illegal
//  proc2mem_addr      in  64   byte address; word index = addr[ADDR_BITS+2:3]
//  proc2mem_data      in  64   store data
//  mem2proc_response  out  4   issue tag for this cycle's command; 0 = rejected or no command
//  mem2proc_data      out 64   load data, valid when mem2proc_tag != 0
//  mem2proc_tag       out  4   completing tag; 0 = no completion this cycle
// BEHAVIOUR
//  Reset:
//  - All slots go free. In-flight requests are discarded and never complete.
//  - mem2proc_tag=0 and mem2proc_data=0. mem2proc_response=0 while reset is high.
//  - Store contents are NOT cleared, so the bench can preload them.
//  Accept:
//  - mem2proc_response is combinational from command and slot state.
//  - A LOAD or STORE is accepted when a slot is free. The response is the lowest free tag.
//  - If no slot is free, response=0, the command has no effect, and the initiator retries.
//  - Command 3 or BUS_NONE: response=0 and no state change.
//  Execution at the accept edge:
//  - STORE writes the word at that edge.
//  - LOAD reads the word at that edge and holds the value in the slot. A store accepted in
//    a later cycle therefore never changes earlier load data; ordering follows accept order.
//  - Upper address bits are ignored, so addresses wrap within the store.
//  Completion:
//  - Each busy slot has a 4-bit countdown loaded with LATENCY at accept.
//  - A command accepted in cycle t shows mem2proc_tag=tag in cycle t+LATENCY.
//    Outputs are registered.
//  - Loads show their captured data. Stores also complete and show data=0, so the
//    initiator can free its bookkeeping.
//  - With one accept per cycle and a fixed latency, at most one completion occurs per
//    cycle, in accept order.
//  - In non-completion cycles mem2proc_tag=0 and mem2proc_data=0.
//  Tag reuse:
//  - A slot frees at the edge that ends its completion cycle, and is reusable from the
//    next cycle. There is no same-cycle reuse.
//  - If an accept and a completion fall in the same cycle, both happen. The accept cannot
//    take the slot that is completing.
//  - Steady-state throughput is min(1, NUM_TAGS/(LATENCY+1)) accepts per cycle.
//  Reset mid-operation: in-flight tags never appear. The first accept after reset gets tag 1.
// CONFIGURATION
//  DMEM_STALL_INJECT_EN defined:
//  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and steps every cycle.
//  - A valid command is also rejected (response=0, no effect) when lfsr[1:0]==2'b00.
//  - Used to exercise the dcache retry path.
//  DMEM_STALL_INJECT_EN undefined: commands are rejected only when all slots are busy;
//  no LFSR is present.
// STRUCTURE
//  - Shared package dmem_pkg holds the BUS_NONE/BUS_LOAD/BUS_STORE constants, the
//    mem_tag_t (4-bit) typedef and the MEM_TAG_NONE=0 constant. The dcache uses the same
//    package.
//  - Sub-module dmem_tag_alloc holds the free vector, the lowest-free priority encoder,
//    the per-slot countdowns, and produces the completing tag.
//  - The top level holds the store array, the per-slot load data, and the output registers.
// TESTING
//  1. Reset; store addr 0x40 data 0xDEAD_BEEF in cycle 0.
//     -> response=1 in cycle 0; tag=1 and data=0 in cycle 4 (LATENCY=4).
//  2. After test 1, load addr 0x40.
//     -> response=1 (slot free again); data 0xDEAD_BEEF with tag 1 four cycles later.
//  3. LATENCY=15, 16 back-to-back loads.
//     -> responses 1..15, 16th response 0; completions tags 1..15 on consecutive cycles
//        starting cycle 15.
//  4. Load 0x80 (tag 1), next cycle store 0x80 := 5.
//     -> load completes with the old value; a later load returns 5.
//  5. Assert reset for one cycle with 3 tags in flight.
//     -> no nonzero tag appears afterwards; the next accept gets tag 1; store contents kept.
//  6. Command 3 with addr 0x40, data 0.
//     -> response 0; word 0x40 unchanged.
//     With DMEM_STALL_INJECT_EN: the first 64 cycles of loads see exactly the rejects
//     predicted by the seed-8'hA5 LFSR model.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: bus command encodings and tag type shared by the dcache and dmem_responder
package dmem_pkg;
  typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2, BUS_ILLEGAL = 2'd3} bus_cmd_t;
  typedef logic [3:0] mem_tag_t;
  localparam mem_tag_t MEM_TAG_NONE = 4'd0;
  function automatic logic is_mem_op(input logic [1:0] c);
    return c == BUS_LOAD || c == BUS_STORE;
  endfunction
endpackage

// File: rtl/dmem_tag_alloc.sv
// dmem_tag_alloc: free-slot tracking, lowest-free tag select and per-slot completion countdowns
module dmem_tag_alloc
  import dmem_pkg::*;
#(
  parameter int NUM_TAGS = 15,
  parameter int LATENCY = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     alloc,
  output mem_tag_t free_tag,
  output mem_tag_t done_tag
);
  logic [NUM_TAGS-1:0] busy;
  logic [3:0] cnt [NUM_TAGS];
  // scan downward so the last free slot seen is the lowest one
  always_comb begin
    free_tag = MEM_TAG_NONE;
    for (int i = NUM_TAGS - 1; i >= 0; i--) free_tag = busy[i] ? free_tag : mem_tag_t'(i + 1);
  end
  // tag to present next cycle: the slot one cycle from completion, or this accept at latency one
  always_comb begin
    done_tag = MEM_TAG_NONE;
    for (int i = 0; i < NUM_TAGS; i++) done_tag = (busy[i] && cnt[i] == 4'd2) ? mem_tag_t'(i + 1) : done_tag;
    done_tag = (LATENCY == 1 && alloc) ? free_tag : done_tag;
  end
  // claim on accept, count down while busy, release at the edge ending the completion cycle
  always_ff @(posedge clock)
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (reset) busy[i] <= 1'b0;
      else if (alloc && free_tag == mem_tag_t'(i + 1)) begin
        busy[i] <= 1'b1;
        cnt[i] <= 4'(LATENCY);
      end else if (busy[i]) begin
        busy[i] <= cnt[i] != 4'd1;
        cnt[i] <= cnt[i] - 4'd1;
      end
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: tagged fixed-latency data memory; DMEM_STALL_INJECT_EN adds LFSR-driven rejects
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int NUM_TAGS = 15,
  parameter int LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [63:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  output mem_tag_t    mem2proc_response,
  output logic [63:0] mem2proc_data,
  output mem_tag_t    mem2proc_tag
);
  logic [63:0] mem [2**ADDR_BITS];
  logic [63:0] slot_data [16];
  logic [ADDR_BITS-1:0] idx;
  logic [63:0] rd;
  logic stall, accept, unused_addr;
  mem_tag_t free_tag, done_tag;
`ifdef DMEM_STALL_INJECT_EN
  logic [7:0] lfsr;
  // free-running reject source, Fibonacci taps 8,6,5,4
  always_ff @(posedge clock) lfsr <= reset ? 8'hA5 : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign stall = lfsr[1:0] == 2'b00;
`else
  assign stall = 1'b0;
`endif
  assign idx = proc2mem_addr[ADDR_BITS+2:3];
  assign unused_addr = ^{proc2mem_addr[63:ADDR_BITS+3], proc2mem_addr[2:0]};
  assign mem2proc_response = (!reset && !stall && is_mem_op(proc2mem_command)) ? free_tag : MEM_TAG_NONE;
  assign accept = mem2proc_response != MEM_TAG_NONE;
  assign rd = proc2mem_command == BUS_LOAD ? mem[idx] : 64'd0;
  dmem_tag_alloc #(.NUM_TAGS(NUM_TAGS), .LATENCY(LATENCY)) u_alloc (
    .clock(clock),
    .reset(reset),
    .alloc(accept),
    .free_tag(free_tag),
    .done_tag(done_tag)
  );
  // stores land at their accept edge; contents survive reset
  always_ff @(posedge clock) if (accept && proc2mem_command == BUS_STORE) mem[idx] <= proc2mem_data;
  // loads snapshot the word at accept so later stores cannot alter them; stores park zero
  always_ff @(posedge clock) if (accept) slot_data[mem2proc_response] <= rd;
  // registered completion outputs, zero whenever nothing completes
  always_ff @(posedge clock) begin
    mem2proc_tag <= reset ? MEM_TAG_NONE : done_tag;
    mem2proc_data <= (reset || done_tag == MEM_TAG_NONE) ? 64'd0 : LATENCY == 1 ? rd : slot_data[done_tag];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus with a completion scoreboard for LATENCY 4 and 15 instances
module tb_dmem_responder;
  import dmem_pkg::*;
  typedef struct {
    int due;
    logic [3:0] tag;
    logic [63:0] data;
  } exp_t;
  logic clock = 1'b0, rst_a, rst_b;
  logic [1:0] cmd_a, cmd_b;
  logic [63:0] addr_a, addr_b, data_a, data_b, out_a, out_b;
  logic [3:0] resp_a, resp_b, tag_a, tag_b;
  int cyc = 0, vectors = 0, miscompares = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  dmem_responder u_a (
    .clock(clock), .reset(rst_a), .proc2mem_command(cmd_a), .proc2mem_addr(addr_a),
    .proc2mem_data(data_a), .mem2proc_response(resp_a), .mem2proc_data(out_a), .mem2proc_tag(tag_a)
  );
  dmem_responder #(.LATENCY(15)) u_b (
    .clock(clock), .reset(rst_b), .proc2mem_command(cmd_b), .proc2mem_addr(addr_b),
    .proc2mem_data(data_b), .mem2proc_response(resp_b), .mem2proc_data(out_b), .mem2proc_tag(tag_b)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // drive one command for one cycle, check its response, record the expected completion
  task automatic issue(input bit b, input logic [1:0] c, input logic [63:0] a, input logic [63:0] d,
                       input logic [3:0] er, input logic [63:0] ed, input bit track);
    if (b) begin cmd_b = c; addr_b = a; data_b = d; end
    else begin cmd_a = c; addr_a = a; data_a = d; end
    @(negedge clock);
    chk(b ? "b_response" : "a_response", b ? resp_b : resp_a, er);
    if (er != 0 && track) begin
      if (b) qb.push_back('{cyc + 15, er, ed});
      else qa.push_back('{cyc + 4, er, ed});
    end
    @(posedge clock);
    #1 cmd_a = BUS_NONE;
    cmd_b = BUS_NONE;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  always @(negedge clock) begin
    if (tag_a != 0) begin
      if (qa.size() == 0) chk("a_spurious_tag", tag_a, 0);
      else begin
        ea = qa.pop_front();
        chk("a_tag", tag_a, ea.tag);
        chk("a_data", out_a, ea.data);
        chk("a_cycle", 64'(cyc), 64'(ea.due));
      end
    end else begin
      if (out_a != 0) chk("a_idle_data", out_a, 0);
      if (qa.size() != 0 && qa[0].due <= cyc) begin
        ea = qa.pop_front();
        chk("a_missing_tag", tag_a, ea.tag);
      end
    end
    if (tag_b != 0) begin
      if (qb.size() == 0) chk("b_spurious_tag", tag_b, 0);
      else begin
        eb = qb.pop_front();
        chk("b_tag", tag_b, eb.tag);
        chk("b_data", out_b, eb.data);
        chk("b_cycle", 64'(cyc), 64'(eb.due));
      end
    end else begin
      if (out_b != 0) chk("b_idle_data", out_b, 0);
      if (qb.size() != 0 && qb[0].due <= cyc) begin
        eb = qb.pop_front();
        chk("b_missing_tag", tag_b, eb.tag);
      end
    end
  end
  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    cmd_a = BUS_NONE; cmd_b = BUS_NONE;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    repeat (2) @(posedge clock);
    #1 cmd_a = BUS_LOAD; cmd_b = BUS_STORE;
    @(negedge clock);
    chk("reset_resp_a", resp_a, 0);
    chk("reset_resp_b", resp_b, 0);
    chk("reset_tag_a", tag_a, 0);
    chk("reset_data_a", out_a, 0);
    chk("reset_tag_b", tag_b, 0);
    @(posedge clock);
    #1 rst_a = 1'b0; rst_b = 1'b0; cmd_a = BUS_NONE; cmd_b = BUS_NONE;
    issue(0, BUS_STORE, 64'h40, 64'hDEAD_BEEF, 1, 0, 1);
    idle(5);
    issue(0, BUS_LOAD, 64'h40, 0, 1, 64'hDEAD_BEEF, 1);
    idle(5);
    issue(0, BUS_STORE, 64'h80, 64'd7, 1, 0, 1);
    idle(5);
    issue(0, BUS_LOAD, 64'h80, 0, 1, 64'd7, 1);
    issue(0, BUS_STORE, 64'h80, 64'd5, 2, 0, 1);
    issue(0, BUS_LOAD, 64'h80, 0, 3, 64'd5, 1);
    idle(6);
    issue(0, BUS_LOAD, 64'h40, 0, 1, 64'hDEAD_BEEF, 1);
    issue(0, BUS_LOAD, 64'h80, 0, 2, 64'd5, 1);
    issue(0, BUS_LOAD, 64'hFFFF_0000_0000_2040, 0, 3, 64'hDEAD_BEEF, 1);
    issue(0, BUS_LOAD, 64'h2080, 0, 4, 64'd5, 1);
    issue(0, BUS_LOAD, 64'h47, 0, 5, 64'hDEAD_BEEF, 1);
    issue(0, BUS_LOAD, 64'h80, 0, 1, 64'd5, 1);
    idle(6);
    issue(0, BUS_LOAD, 64'h40, 0, 1, 0, 0);
    issue(0, BUS_LOAD, 64'h40, 0, 2, 0, 0);
    issue(0, BUS_LOAD, 64'h40, 0, 3, 0, 0);
    rst_a = 1'b1;
    cmd_a = BUS_STORE;
    @(negedge clock);
    chk("midreset_resp_a", resp_a, 0);
    @(posedge clock);
    #1 rst_a = 1'b0;
    cmd_a = BUS_NONE;
    idle(20);
    issue(0, BUS_LOAD, 64'h40, 0, 1, 64'hDEAD_BEEF, 1);
    idle(6);
    issue(0, 2'd3, 64'h40, 0, 0, 0, 1);
    issue(0, BUS_NONE, 64'h40, 0, 0, 0, 1);
    issue(0, BUS_LOAD, 64'h40, 0, 1, 64'hDEAD_BEEF, 1);
    idle(6);
    for (int i = 0; i < 15; i++) issue(1, BUS_STORE, 64'(i * 8), 64'h1111 * 64'(i + 1), 4'(i + 1), 0, 1);
    idle(20);
    for (int i = 0; i < 16; i++)
      issue(1, BUS_LOAD, 64'(i * 8), 0, i < 15 ? 4'(i + 1) : 4'd0, 64'h1111 * 64'(i + 1), 1);
    idle(25);
    chk("a_queue_drained", 64'(qa.size()), 0);
    chk("b_queue_drained", 64'(qb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
